// File: rtl/ncpu32k_mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ncpu32k_mmu_pkg
// Description : Constants and types shared by the ITLB and its refill
//               walker: PTE/TLB bit positions, walker state encoding and
//               default index widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ncpu32k_mmu_pkg;

    // Address width of the core
    localparam int c_ADDR_DW = 32;

    // Page table entry bit positions (also the ITLB high-word layout)
    localparam int c_PTE_P  = 0;
    localparam int c_PTE_UX = 3;
    localparam int c_PTE_RX = 4;
    localparam int c_PTE_S  = 8;

    // ITLB low-word valid bit
    localparam int c_TLBL_V = 0;

    // Default geometry
    localparam int c_DEF_PAGE_SIZE_LOG2  = 12;
    localparam int c_DEF_ITLB_NSETS_LOG2 = 7;
    localparam int c_DEF_VPN_DW          = c_ADDR_DW - c_DEF_PAGE_SIZE_LOG2;
    localparam int c_DEF_L2_DW           = c_DEF_PAGE_SIZE_LOG2 - 2;
    localparam int c_DEF_L1_DW           = c_DEF_VPN_DW - c_DEF_L2_DW;

    // Refill walker states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_L1_REQ  = 3'd1,
        S_L1_WAIT = 3'd2,
        S_L2_REQ  = 3'd3,
        S_L2_WAIT = 3'd4,
        S_WRITE   = 3'd5,
        S_DRAIN   = 3'd6
    } walk_state_t;

endpackage
`default_nettype wire

// File: rtl/ncpu32k_itlb_refill_if.sv
`default_nettype none
// ============================================================================
// Module      : ncpu32k_itlb_refill_if
// Description : Bundle between the ITLB refill walker and its environment:
//               miss request, page-table base, flush, memory read port,
//               ITLB write ports and completion status.
// Revision    : 1.0 - initial release
// ============================================================================
interface ncpu32k_itlb_refill_if #(
    parameter int CONFIG_IMMU_PAGE_SIZE_LOG2 = ncpu32k_mmu_pkg::c_DEF_PAGE_SIZE_LOG2,
    parameter int CONFIG_ITLB_NSETS_LOG2     = ncpu32k_mmu_pkg::c_DEF_ITLB_NSETS_LOG2
);
    localparam int c_VPN_DW = 32 - CONFIG_IMMU_PAGE_SIZE_LOG2;
    localparam int c_TLB_AW = CONFIG_ITLB_NSETS_LOG2;

    // Miss request from fetch
    logic                miss_valid;
    logic [c_VPN_DW-1:0] miss_vpn;
    logic                miss_ready;
    logic [31:0]         ptbr;
    logic                flush;

    // Memory read port
    logic                mem_req_valid;
    logic [31:0]         mem_req_addr;
    logic                mem_req_ready;
    logic                mem_resp_valid;
    logic [31:0]         mem_resp_data;
    logic                mem_resp_err;

    // ITLB write ports
    logic [c_TLB_AW-1:0] msr_imm_tlbl_idx;
    logic [31:0]         msr_imm_tlbl_nxt;
    logic                msr_imm_tlbl_we;
    logic [c_TLB_AW-1:0] msr_imm_tlbh_idx;
    logic [31:0]         msr_imm_tlbh_nxt;
    logic                msr_imm_tlbh_we;

    // Completion
    logic                refill_done;
    logic                refill_fault;

    // Walker side
    modport master (
        input  miss_valid, miss_vpn, ptbr, flush,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output miss_ready, mem_req_valid, mem_req_addr,
        output msr_imm_tlbl_idx, msr_imm_tlbl_nxt, msr_imm_tlbl_we,
        output msr_imm_tlbh_idx, msr_imm_tlbh_nxt, msr_imm_tlbh_we,
        output refill_done, refill_fault
    );

    // Environment side (fetch, memory, ITLB)
    modport slave (
        output miss_valid, miss_vpn, ptbr, flush,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  miss_ready, mem_req_valid, mem_req_addr,
        input  msr_imm_tlbl_idx, msr_imm_tlbl_nxt, msr_imm_tlbl_we,
        input  msr_imm_tlbh_idx, msr_imm_tlbh_nxt, msr_imm_tlbh_we,
        input  refill_done, refill_fault
    );

endinterface
`default_nettype wire

// File: rtl/ncpu32k_itlb_refill.sv
`default_nettype none
// ============================================================================
// Module      : ncpu32k_itlb_refill
// Description : Hardware ITLB refill walker. Walks a two-level page table on
//               an ITLB miss and writes the resulting entry into the ITLB.
// Revision    : 1.0 - initial release
// ============================================================================
module ncpu32k_itlb_refill
    import ncpu32k_mmu_pkg::*;
#(
    parameter int CONFIG_IMMU_PAGE_SIZE_LOG2 = c_DEF_PAGE_SIZE_LOG2,
    parameter int CONFIG_ITLB_NSETS_LOG2     = c_DEF_ITLB_NSETS_LOG2
)(
    input wire                    clk,
    input wire                    rst,
    ncpu32k_itlb_refill_if.master bus
);

    localparam int c_PS       = CONFIG_IMMU_PAGE_SIZE_LOG2;
    localparam int c_VPN_DW   = c_ADDR_DW - c_PS;
    localparam int c_L2_DW    = c_PS - 2;
    localparam int c_L1_DW    = c_VPN_DW - c_L2_DW;
    localparam int c_TLB_AW   = CONFIG_ITLB_NSETS_LOG2;
    localparam int c_BASE1_DW = c_ADDR_DW - (c_L1_DW + 2);

    walk_state_t           r_state;
    walk_state_t           w_next_state;

    // Only the table-base bits that actually form addresses are kept
    logic [c_VPN_DW-1:0]   r_vpn;
    logic [c_BASE1_DW-1:0] r_l1_base;
    logic [c_VPN_DW-1:0]   r_l2_base;
    logic [31:0]           r_leaf;
    // A flush seen while a request is still waiting for mem_req_ready
    logic                  r_abort;

    logic [c_L1_DW-1:0]    w_l1_idx;
    logic [c_L2_DW-1:0]    w_l2_idx;
    logic [31:0]           w_l1_addr;
    logic [31:0]           w_l2_addr;
    logic [31:0]           w_tlbl;
    logic                  w_resp_bad;

    logic                  w_accept;
    logic                  w_latch_pte1;
    logic                  w_latch_leaf;
    logic                  w_is_req;
    logic                  w_miss_ready;
    logic                  w_req_valid;
    logic [31:0]           w_req_addr;
    logic                  w_we;
    logic                  w_done;
    logic                  w_fault;
    logic [c_TLB_AW-1:0]   w_tlb_idx;
    logic [31:0]           w_tlbl_nxt;
    logic [31:0]           w_tlbh_nxt;

    assign w_l1_idx   = r_vpn[c_VPN_DW-1:c_L2_DW];
    assign w_l2_idx   = r_vpn[c_L2_DW-1:0];
    assign w_l1_addr  = {r_l1_base, w_l1_idx, 2'b00};
    assign w_l2_addr  = {r_l2_base, w_l2_idx, 2'b00};
    assign w_resp_bad = bus.mem_resp_err | ~bus.mem_resp_data[c_PTE_P];

    // New ITLB low word: the VPN tag with only the valid bit set
    always_comb begin
        w_tlbl              = '0;
        w_tlbl[31:c_PS]     = r_vpn;
        w_tlbl[c_TLBL_V]    = 1'b1;
    end

    // Walker state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_miss_ready = 1'b0;
        w_req_valid  = 1'b0;
        w_req_addr   = '0;
        w_we         = 1'b0;
        w_done       = 1'b0;
        w_fault      = 1'b0;
        w_accept     = 1'b0;
        w_latch_pte1 = 1'b0;
        w_latch_leaf = 1'b0;
        w_is_req     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Flush outranks a new miss in the same cycle
                w_miss_ready = ~bus.flush;
                if (bus.miss_valid && !bus.flush) begin
                    w_accept     = 1'b1;
                    w_next_state = S_L1_REQ;
                end
            end
            S_L1_REQ, S_L2_REQ: begin
                w_is_req    = 1'b1;
                w_req_valid = 1'b1;
                w_req_addr  = (r_state == S_L1_REQ) ? w_l1_addr : w_l2_addr;
                if (bus.mem_req_ready) begin
                    // An aborted read is still issued, so its reply must be drained
                    if (bus.flush || r_abort) begin
                        w_next_state = S_DRAIN;
                    end else if (r_state == S_L1_REQ) begin
                        w_next_state = S_L1_WAIT;
                    end else begin
                        w_next_state = S_L2_WAIT;
                    end
                end
            end
            S_L1_WAIT, S_L2_WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (bus.flush) begin
                        w_next_state = S_IDLE;
                    end else if (w_resp_bad) begin
                        w_done       = 1'b1;
                        w_fault      = 1'b1;
                        w_next_state = S_IDLE;
                    end else if (r_state == S_L1_WAIT) begin
                        w_latch_pte1 = 1'b1;
                        w_next_state = S_L2_REQ;
                    end else begin
                        w_latch_leaf = 1'b1;
                        w_next_state = S_WRITE;
                    end
                end else if (bus.flush) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_WRITE: begin
                w_we         = ~bus.flush;
                w_done       = ~bus.flush;
                w_next_state = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.mem_resp_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Walk context: missing VPN, table bases, leaf PTE and pending abort
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vpn     <= '0;
            r_l1_base <= '0;
            r_l2_base <= '0;
            r_leaf    <= '0;
            r_abort   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_vpn     <= bus.miss_vpn;
                r_l1_base <= bus.ptbr[31:c_L1_DW+2];
            end
            if (w_latch_pte1) begin
                r_l2_base <= bus.mem_resp_data[31:c_PS];
            end
            if (w_latch_leaf) begin
                r_leaf <= bus.mem_resp_data;
            end
            r_abort <= w_is_req & ~bus.mem_req_ready & (bus.flush | r_abort);
        end
    end

    // ITLB write data is only presented during the WRITE cycle
    always_comb begin
        w_tlb_idx  = '0;
        w_tlbl_nxt = '0;
        w_tlbh_nxt = '0;
        if (r_state == S_WRITE) begin
            w_tlb_idx  = r_vpn[c_TLB_AW-1:0];
            w_tlbl_nxt = w_tlbl;
            w_tlbh_nxt = r_leaf;
        end
    end

    assign bus.miss_ready       = w_miss_ready;
    assign bus.mem_req_valid    = w_req_valid;
    assign bus.mem_req_addr     = w_req_addr;
    assign bus.msr_imm_tlbl_idx = w_tlb_idx;
    assign bus.msr_imm_tlbl_nxt = w_tlbl_nxt;
    assign bus.msr_imm_tlbl_we  = w_we;
    assign bus.msr_imm_tlbh_idx = w_tlb_idx;
    assign bus.msr_imm_tlbh_nxt = w_tlbh_nxt;
    assign bus.msr_imm_tlbh_we  = w_we;
    assign bus.refill_done      = w_done;
    assign bus.refill_fault     = w_fault;

endmodule
`default_nettype wire

// File: tb/tb_ncpu32k_itlb_refill.sv
`default_nettype none
// ============================================================================
// Module      : tb_ncpu32k_itlb_refill
// Description : Self-checking bench for the ITLB refill walker: a table of
//               directed walks, random walks against a reference model, and
//               hand-written flush/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ncpu32k_itlb_refill;

    localparam int PS    = 12;
    localparam int NS    = 7;
    localparam int L2_DW = PS - 2;
    localparam int L1_DW = 32 - PS - L2_DW;

    typedef struct {
        logic [19:0] vpn;
        logic [31:0] ptbr;
        logic [31:0] pte1;
        logic        err1;
        logic [31:0] pte2;
        logic        err2;
        int          s1;
        int          s2;
        int          e_nreq;
        logic        e_fault;
        logic [31:0] e_a1;
        logic [31:0] e_a2;
        logic [6:0]  e_idx;
        logic [31:0] e_tlbl;
        logic [31:0] e_tlbh;
        int          e_done;
    } vec_t;

    typedef struct {
        logic        ready_idle;
        int          nreq;
        logic [31:0] a1;
        logic [31:0] a2;
        int          unstable;
        int          ndone;
        logic        fault;
        int          done_cyc;
        int          nwe_l;
        int          nwe_h;
        logic [6:0]  idx_l;
        logic [6:0]  idx_h;
        logic [31:0] tlbl;
        logic [31:0] tlbh;
        int          ready_early;
        logic        ready_after;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ncpu32k_itlb_refill_if #(
        .CONFIG_IMMU_PAGE_SIZE_LOG2 (PS),
        .CONFIG_ITLB_NSETS_LOG2     (NS)
    ) bus ();

    ncpu32k_itlb_refill #(
        .CONFIG_IMMU_PAGE_SIZE_LOG2 (PS),
        .CONFIG_ITLB_NSETS_LOG2     (NS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.miss_valid     = 1'b0;
        bus.miss_vpn       = '0;
        bus.ptbr           = '0;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
    endtask

    function automatic vec_t mkv(
        input logic [19:0] vpn, input logic [31:0] ptbr,
        input logic [31:0] pte1, input logic err1,
        input logic [31:0] pte2, input logic err2,
        input int s1, input int s2, input int e_nreq, input logic e_fault,
        input logic [31:0] e_a1, input logic [31:0] e_a2, input logic [6:0] e_idx,
        input logic [31:0] e_tlbl, input logic [31:0] e_tlbh, input int e_done);
        vec_t v;
        v.vpn = vpn;  v.ptbr = ptbr; v.pte1 = pte1; v.err1 = err1;
        v.pte2 = pte2; v.err2 = err2; v.s1 = s1; v.s2 = s2;
        v.e_nreq = e_nreq; v.e_fault = e_fault; v.e_a1 = e_a1; v.e_a2 = e_a2;
        v.e_idx = e_idx; v.e_tlbl = e_tlbl; v.e_tlbh = e_tlbh; v.e_done = e_done;
        return v;
    endfunction

    // Reference model: expected walk outcome from the page-table rules
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        logic [31:0] vpn32;
        logic [31:0] l1;
        logic [31:0] l2;
        r      = v;
        vpn32  = 32'(v.vpn);
        l1     = vpn32 / (32'd1 << L2_DW);
        l2     = vpn32 % (32'd1 << L2_DW);
        r.e_a1 = (v.ptbr / (32'd1 << (L1_DW + 2))) * (32'd1 << (L1_DW + 2)) + l1 * 4;
        r.e_a2 = (v.pte1 / (32'd1 << PS)) * (32'd1 << PS) + l2 * 4;
        r.e_idx  = 7'(vpn32 % (32'd1 << NS));
        r.e_tlbl = vpn32 * (32'd1 << PS) + 32'd1;
        r.e_tlbh = v.pte2;
        if (v.err1 || (v.pte1 % 2 == 0)) begin
            r.e_nreq = 1; r.e_fault = 1'b1; r.e_done = 2 + v.s1;
        end else if (v.err2 || (v.pte2 % 2 == 0)) begin
            r.e_nreq = 2; r.e_fault = 1'b1; r.e_done = 4 + v.s1 + v.s2;
        end else begin
            r.e_nreq = 2; r.e_fault = 1'b0; r.e_done = 5 + v.s1 + v.s2;
        end
        return r;
    endfunction

    // Present one miss, act as a zero-wait memory (plus optional ready stalls)
    task automatic run_walk(input vec_t v, output obs_t o);
        int resp_at;
        int resp_lvl;
        int stall;
        int lvl;
        o = '{default: 0};
        o.done_cyc = -1;
        resp_at  = -1;
        resp_lvl = 0;
        stall    = 0;
        @(negedge clk);
        drive_idle();
        bus.miss_valid = 1'b1;
        bus.miss_vpn   = v.vpn;
        bus.ptbr       = v.ptbr;
        #1;
        o.ready_idle = bus.miss_ready;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            drive_idle();
            bus.miss_vpn      = 20'($urandom);
            bus.ptbr          = $urandom;
            bus.mem_resp_data = $urandom;
            if (c == resp_at) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = (resp_lvl == 0) ? v.pte1 : v.pte2;
                bus.mem_resp_err   = (resp_lvl == 0) ? v.err1 : v.err2;
            end
            #1;
            if (bus.mem_req_valid) begin
                lvl = o.nreq;
                if (stall == 0) begin
                    if (lvl == 0) o.a1 = bus.mem_req_addr;
                    else if (lvl == 1) o.a2 = bus.mem_req_addr;
                end else if (bus.mem_req_addr != ((lvl == 0) ? o.a1 : o.a2)) begin
                    o.unstable++;
                end
                if (stall < ((lvl == 0) ? v.s1 : v.s2)) begin
                    stall++;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    o.nreq++;
                    resp_at  = c + 1;
                    resp_lvl = lvl;
                    stall    = 0;
                end
            end
            if (bus.msr_imm_tlbl_we) begin
                o.nwe_l++; o.idx_l = bus.msr_imm_tlbl_idx; o.tlbl = bus.msr_imm_tlbl_nxt;
            end
            if (bus.msr_imm_tlbh_we) begin
                o.nwe_h++; o.idx_h = bus.msr_imm_tlbh_idx; o.tlbh = bus.msr_imm_tlbh_nxt;
            end
            if (bus.refill_done) begin
                o.ndone++;
                if (o.done_cyc < 0) begin
                    o.done_cyc = c;
                    o.fault    = bus.refill_fault;
                end
            end
            if (o.done_cyc < 0 && bus.miss_ready) o.ready_early++;
            if (o.done_cyc >= 0 && c == o.done_cyc + 1) o.ready_after = bus.miss_ready;
            if (o.done_cyc >= 0 && c >= o.done_cyc + 3) break;
        end
        drive_idle();
    endtask

    task automatic check_vec(input int k, input vec_t v, input obs_t o);
        string p;
        p = $sformatf("v%0d_", k);
        chk({p, "ready_idle"},  32'(o.ready_idle), 32'd1);
        chk({p, "nreq"},        o.nreq, v.e_nreq);
        chk({p, "l1_addr"},     o.a1, v.e_a1);
        if (v.e_nreq == 2) chk({p, "l2_addr"}, o.a2, v.e_a2);
        chk({p, "addr_stable"}, o.unstable, 0);
        chk({p, "ndone"},       o.ndone, 1);
        chk({p, "fault"},       32'(o.fault), 32'(v.e_fault));
        chk({p, "done_cycle"},  o.done_cyc, v.e_done);
        chk({p, "nwe_l"},       o.nwe_l, v.e_fault ? 0 : 1);
        chk({p, "nwe_h"},       o.nwe_h, v.e_fault ? 0 : 1);
        if (!v.e_fault) begin
            chk({p, "idx_l"},   32'(o.idx_l), 32'(v.e_idx));
            chk({p, "idx_h"},   32'(o.idx_h), 32'(v.e_idx));
            chk({p, "tlbl"},    o.tlbl, v.e_tlbl);
            chk({p, "tlbh"},    o.tlbh, v.e_tlbh);
        end
        chk({p, "ready_busy"},  o.ready_early, 0);
        chk({p, "ready_after"}, 32'(o.ready_after), 32'd1);
    endtask

    task automatic start_miss(input logic [19:0] vpn, input logic [31:0] ptbr, input logic fl);
        @(negedge clk);
        drive_idle();
        bus.miss_valid = 1'b1;
        bus.miss_vpn   = vpn;
        bus.ptbr       = ptbr;
        bus.flush      = fl;
        #1;
    endtask

    task automatic step(input logic rv, input logic [31:0] data, input logic rdy,
                        input logic fl, input logic r);
        @(negedge clk);
        drive_idle();
        bus.mem_resp_valid = rv;
        bus.mem_resp_data  = data;
        bus.mem_req_ready  = rdy;
        bus.flush          = fl;
        rst                = r;
        #1;
    endtask

    task automatic quiet(input int n, output int nreq, output int nwe, output int ndone,
                         output int nready);
        nreq = 0; nwe = 0; ndone = 0; nready = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            if (bus.mem_req_valid) nreq++;
            if (bus.msr_imm_tlbl_we || bus.msr_imm_tlbh_we) nwe++;
            if (bus.refill_done) ndone++;
            if (bus.miss_ready) nready++;
        end
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        obs_t o;
        int   nreq, nwe, ndone, nready;

        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_miss_ready", 32'(bus.miss_ready), 32'd1);
        chk("rst_req_valid",  32'(bus.mem_req_valid), 32'd0);
        chk("rst_req_addr",   bus.mem_req_addr, 32'd0);
        chk("rst_we",         32'({bus.msr_imm_tlbl_we, bus.msr_imm_tlbh_we}), 32'd0);
        chk("rst_done",       32'({bus.refill_done, bus.refill_fault}), 32'd0);
        chk("rst_tlb_nxt",    bus.msr_imm_tlbl_nxt | bus.msr_imm_tlbh_nxt, 32'd0);
        chk("rst_tlb_idx",    32'(bus.msr_imm_tlbl_idx | bus.msr_imm_tlbh_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed walks: inputs and hand-derived expectations
        tbl[0] = mkv(20'h12345, 32'h0010_0000, 32'h0020_0001, 0, 32'h0ABC_D019, 0, 0, 0,
                     2, 0, 32'h0010_0120, 32'h0020_0D14, 7'h45, 32'h1234_5001, 32'h0ABC_D019, 5);
        tbl[1] = mkv(20'h12345, 32'h0010_0000, 32'h0020_0000, 0, 32'h0ABC_D019, 0, 0, 0,
                     1, 1, 32'h0010_0120, 32'h0, 7'h0, 32'h0, 32'h0, 2);
        tbl[2] = mkv(20'h12345, 32'h0010_0000, 32'h0020_0001, 0, 32'h0ABC_D019, 1, 0, 0,
                     2, 1, 32'h0010_0120, 32'h0020_0D14, 7'h0, 32'h0, 32'h0, 4);
        tbl[3] = mkv(20'h12345, 32'h0010_0000, 32'h0020_0001, 0, 32'h0ABC_D019, 0, 5, 0,
                     2, 0, 32'h0010_0120, 32'h0020_0D14, 7'h45, 32'h1234_5001, 32'h0ABC_D019, 10);
        tbl[4] = mkv(20'hFFFFF, 32'h8000_0000, 32'h1234_5001, 0, 32'hFFFF_F119, 0, 0, 3,
                     2, 0, 32'h8000_0FFC, 32'h1234_5FFC, 7'h7F, 32'hFFFF_F001, 32'hFFFF_F119, 8);
        tbl[5] = mkv(20'h12345, 32'h0010_0000, 32'h0020_0001, 1, 32'h0ABC_D019, 0, 0, 0,
                     1, 1, 32'h0010_0120, 32'h0, 7'h0, 32'h0, 32'h0, 2);
        tbl[6] = mkv(20'h12345, 32'h0010_0000, 32'h0020_0001, 0, 32'h0ABC_D018, 0, 0, 0,
                     2, 1, 32'h0010_0120, 32'h0020_0D14, 7'h0, 32'h0, 32'h0, 4);
        for (int k = 0; k < 7; k++) begin
            run_walk(tbl[k], o);
            check_vec(k, tbl[k], o);
        end

        // miss_valid together with flush in IDLE: not accepted
        start_miss(20'h12345, 32'h0010_0000, 1'b1);
        quiet(4, nreq, nwe, ndone, nready);
        chk("mflush_nreq",   nreq, 0);
        chk("mflush_done",   ndone, 0);
        chk("mflush_ready",  nready, 4);

        // Flush in L1_WAIT: drain the reply, no done
        start_miss(20'h12345, 32'h0010_0000, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("fwait_req_addr", bus.mem_req_addr, 32'h0010_0120);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("fwait_done_flush", 32'(bus.refill_done), 32'd0);
        step(1'b1, 32'h0020_0001, 1'b0, 1'b0, 1'b0);
        chk("fwait_drain_ready", 32'(bus.miss_ready), 32'd0);
        chk("fwait_drain_done",  32'(bus.refill_done), 32'd0);
        quiet(4, nreq, nwe, ndone, nready);
        chk("fwait_nreq",  nreq, 0);
        chk("fwait_we",    nwe, 0);
        chk("fwait_done",  ndone, 0);
        chk("fwait_ready", nready, 4);

        // Flush while a request is stalled: request held, then drained
        start_miss(20'h12345, 32'h0010_0000, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("freq_held", 32'(bus.mem_req_valid), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0020_0001, 1'b0, 1'b0, 1'b0);
        chk("freq_drain_ready", 32'(bus.miss_ready), 32'd0);
        quiet(4, nreq, nwe, ndone, nready);
        chk("freq_nreq",  nreq, 0);
        chk("freq_done",  ndone + nwe, 0);
        chk("freq_ready", nready, 4);

        // Reset in L2_WAIT: idle next cycle, late reply ignored
        start_miss(20'h12345, 32'h0010_0000, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0020_0001, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("rwait_l2_addr", bus.mem_req_addr, 32'h0020_0D14);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0ABC_D019, 1'b0, 1'b0, 1'b0);
        chk("rwait_ready", 32'(bus.miss_ready), 32'd1);
        chk("rwait_we",    32'(bus.msr_imm_tlbl_we | bus.msr_imm_tlbh_we), 32'd0);
        quiet(4, nreq, nwe, ndone, nready);
        chk("rwait_nreq",  nreq, 0);
        chk("rwait_quiet", nwe + ndone, 0);

        // Flush during WRITE suppresses we and done
        start_miss(20'h12345, 32'h0010_0000, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0020_0001, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0ABC_D019, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("fwr_we",   32'(bus.msr_imm_tlbl_we | bus.msr_imm_tlbh_we), 32'd0);
        chk("fwr_done", 32'(bus.refill_done), 32'd0);
        quiet(3, nreq, nwe, ndone, nready);
        chk("fwr_ready", nready, 3);
        chk("fwr_quiet", nreq + nwe + ndone, 0);

        // Random walks against the reference model
        for (int k = 0; k < 40; k++) begin
            v = '{default: 0};
            v.vpn     = 20'($urandom);
            v.ptbr    = $urandom & 32'hFFFF_F000;
            v.pte1    = $urandom;
            v.pte1[0] = ($urandom_range(0, 7) != 0);
            v.err1    = ($urandom_range(0, 9) == 0);
            v.pte2    = $urandom;
            v.pte2[0] = ($urandom_range(0, 7) != 0);
            v.err2    = ($urandom_range(0, 9) == 0);
            v.s1      = $urandom_range(0, 3);
            v.s2      = $urandom_range(0, 3);
            v = model(v);
            run_walk(v, o);
            check_vec(100 + k, v, o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
